alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one combinational 32-bit ALU between two requesters (port 0, port 1).
- ALU interface: src1, src2, 4-bit ALU_control, 3-bit bonus_control; returns result, zero, cout, overflow.
- Arbitrates with round-robin priority, latches operands, drives the ALU for one cycle, registers the result, and returns it on a valid/ready response channel tagged with the winning port.
- Rejects illegal opcodes without using the ALU.

Parameters:
- DATA_W, 32, operand/result width.
- RR_INIT, 0, port holding priority after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset; sampled on posedge clk.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_src1  in  DATA_W  port 0 operand 1.
- req0_src2  in  DATA_W  port 0 operand 2.
- req0_op  in  4  port 0 ALU_control.
- req0_bonus  in  3  port 0 bonus_control.
- req1_valid, req1_ready, req1_src1, req1_src2, req1_op, req1_bonus: as port 0.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_port  out  1  port that issued the request.
- rsp_result  out  DATA_W  registered ALU result.
- rsp_zcv  out  3  {zero, cout, overflow}.
- rsp_err  out  1  illegal opcode/bonus combination.
- alu_src1  out  DATA_W  to ALU src1.
- alu_src2  out  DATA_W  to ALU src2.
- alu_ctrl  out  4  to ALU ALU_control.
- alu_bonus  out  3  to ALU bonus_control.
- alu_result  in  DATA_W  from ALU.
- alu_zero  in  1  from ALU.
- alu_cout  in  1  from ALU.
- alu_overflow  in  1  from ALU.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE; priority pointer=RR_INIT.
  - All outputs 0: rsp_valid, rsp_port, rsp_result, rsp_zcv, rsp_err, alu_*.
  - req*_ready are combinational from state and therefore 0 during reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready=1 only for the granted port: the single valid port, or the priority port if both are valid.
  - On the handshake, latch src1/src2/op/bonus/port and update the priority pointer to the other port.
  - Legal op goes to EXEC; illegal op goes directly to RESP with rsp_err=1, rsp_result=0, rsp_zcv=000.
- Legal op set:
  - op in {0 AND, 1 OR, 2 ADD, 6 SUB, 12 NOR, 13 NAND}, with bonus ignored.
  - op 7 with bonus in {0 SLT, 1 SGT, 2 SLE, 3 SGE, 4 SNE, 6 SEQ}.
  - Everything else is illegal.
- EXEC (exactly 1 cycle):
  - alu_* outputs are driven from the latched registers.
  - Outside EXEC, alu_* hold their last value (no toggling) and are 0 after reset.
  - At the end of EXEC, capture alu_result into rsp_result and alu_zero into rsp_zcv[2].
  - rsp_zcv[1:0] = {alu_cout, alu_overflow} for op 2/6; forced to 00 for all other ops.
  - Go to RESP.
- RESP:
  - rsp_valid=1; payload stays stable until rsp_ready=1.
  - On the handshake, go to IDLE.
  - No new request is accepted in RESP.
- Latency: accept at cycle t, rsp_valid at t+2 (legal op) or t+1 (illegal op). Back-to-back throughput is one op per 3 cycles.
- Fairness: with both ports continuously valid, grants strictly alternate.
- Reset mid-operation: an in-flight op is discarded, no response is produced, and the priority pointer returns to RR_INIT.
- A request withdrawn (valid deasserted) before its handshake is not remembered.
- reqN_ready never asserts for both ports in the same cycle.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7, OP_NOR=12, OP_NAND=13.
  - Bonus constants B_SLT=0, B_SGT=1, B_SLE=2, B_SGE=3, B_SNE=4, B_SEQ=6.
  - FSM state encoding.
  - Function op_legal(op, bonus).
- One sub-module, rr_arb2: 2-way round-robin grant with pointer update on accept.
- The ALU itself is instantiated beside this block, not inside it.

Test Plan:
- Port 0 ADD 0x7FFFFFFF + 0x00000001 -> rsp_valid 2 cycles after accept; result 0x80000000, zcv=001, port=0, err=0.
- Port 1 SUB 0x00000005 - 0x00000005 -> result 0x00000000, zcv=110; same operands with op 0 (AND) -> result 0x00000005, zcv=000 (c/v masked).
- Both ports valid for 4 requests each, starting with RR_INIT=0 -> grant order 0,1,0,1,…; rsp_port alternates; each response matches a reference ALU model.
- Port 0 op=7, bonus=5 -> rsp_valid 1 cycle after accept, err=1, result=0, ALU outputs unchanged.
- rsp_ready held low 5 cycles during RESP -> payload stable, req0_ready and req1_ready stay 0; rsp_ready=1 -> IDLE next cycle.
- rst_n=0 during EXEC -> next cycle all outputs 0, no response; after release, the pending port-1 request is granted first only if port 0 is idle (pointer=RR_INIT).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/bonus encodings, arbiter FSM states and opcode legality check
// for the shared-ALU request arbiter.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_NAND = 4'd13;

  localparam logic [2:0] B_SLT = 3'd0;
  localparam logic [2:0] B_SGT = 3'd1;
  localparam logic [2:0] B_SLE = 3'd2;
  localparam logic [2:0] B_SGE = 3'd3;
  localparam logic [2:0] B_SNE = 3'd4;
  localparam logic [2:0] B_SEQ = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Bonus only qualifies the compare family (op 7); other legal ops ignore it.
  function automatic logic op_legal(input logic [3:0] op, input logic [2:0] bonus);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_NAND: ok = 1'b1;
      OP_SLT: begin
        case (bonus)
          B_SLT, B_SGT, B_SLE, B_SGE, B_SNE, B_SEQ: ok = 1'b1;
          default:                                  ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_has_cv(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port holding priority and
// moves to the other port whenever a grant is issued.
module rr_arb2 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_port
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (valid0 && (!valid1 || !ptr_q)) gnt0 = 1'b1;
      else if (valid1)                   gnt1 = 1'b1;
    end
    gnt_port = gnt1;
    // A grant is always accepted, so the winner gives up priority here.
    ptr_d = (gnt0 || gnt1) ? gnt0 : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= RR_INIT;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters: arbitrates,
// drives the ALU for one cycle, and returns a registered, port-tagged response.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter logic        RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic [3:0]        req0_op,
  input  logic [2:0]        req0_bonus,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  input  logic [3:0]        req1_op,
  input  logic [2:0]        req1_bonus,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_port,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_zcv,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [3:0]        alu_ctrl,
  output logic [2:0]        alu_bonus,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow
);

  state_e state_q, state_d;

  logic gnt0, gnt1, gnt_port, arb_en, hs;

  logic [DATA_W-1:0] sel_src1, sel_src2;
  logic [3:0]        sel_op;
  logic [2:0]        sel_bonus;

  // The ALU-facing registers double as the operand latch, so the ALU inputs
  // only change on a legal accept and hold otherwise.
  logic [DATA_W-1:0] alu_src1_q, alu_src1_d;
  logic [DATA_W-1:0] alu_src2_q, alu_src2_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [2:0]        alu_bonus_q, alu_bonus_d;
  logic              port_q, port_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]        rsp_zcv_q, rsp_zcv_d;
  logic              rsp_err_q, rsp_err_d;

  assign arb_en = rst_n && (state_q == ST_IDLE);

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (arb_en),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .gnt_port (gnt_port)
  );

  assign hs = gnt0 || gnt1;

  always_comb begin
    sel_src1  = gnt1 ? req1_src1  : req0_src1;
    sel_src2  = gnt1 ? req1_src2  : req0_src2;
    sel_op    = gnt1 ? req1_op    : req0_op;
    sel_bonus = gnt1 ? req1_bonus : req0_bonus;
  end

  always_comb begin
    state_d      = state_q;
    alu_src1_d   = alu_src1_q;
    alu_src2_d   = alu_src2_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_bonus_d  = alu_bonus_q;
    port_d       = port_q;
    rsp_result_d = rsp_result_q;
    rsp_zcv_d    = rsp_zcv_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          port_d = gnt_port;
          if (op_legal(sel_op, sel_bonus)) begin
            alu_src1_d  = sel_src1;
            alu_src2_d  = sel_src2;
            alu_ctrl_d  = sel_op;
            alu_bonus_d = sel_bonus;
            state_d     = ST_EXEC;
          end else begin
            rsp_result_d = '0;
            rsp_zcv_d    = '0;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zcv_d    = {alu_zero,
                        op_has_cv(alu_ctrl_q) ? {alu_cout, alu_overflow} : 2'b00};
        rsp_err_d    = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      alu_ctrl_q   <= '0;
      alu_bonus_q  <= '0;
      port_q       <= 1'b0;
      rsp_result_q <= '0;
      rsp_zcv_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_src1_q   <= alu_src1_d;
      alu_src2_q   <= alu_src2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_bonus_q  <= alu_bonus_d;
      port_q       <= port_d;
      rsp_result_q <= rsp_result_d;
      rsp_zcv_q    <= rsp_zcv_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_port   = port_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zcv    = rsp_zcv_q;
  assign rsp_err    = rsp_err_q;
  assign alu_src1   = alu_src1_q;
  assign alu_src2   = alu_src2_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_bonus  = alu_bonus_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU beside the DUT and
// hand-computed expected responses.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_op, req1_op;
  logic [2:0]  req0_bonus, req1_bonus;
  logic        rsp_valid, rsp_ready, rsp_port, rsp_err;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_zcv;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_bonus;
  logic        alu_zero, alu_cout, alu_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arb #(
    .DATA_W  (32),
    .RR_INIT (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_src1    (req0_src1),
    .req0_src2    (req0_src2),
    .req0_op      (req0_op),
    .req0_bonus   (req0_bonus),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_src1    (req1_src1),
    .req1_src2    (req1_src2),
    .req1_op      (req1_op),
    .req1_bonus   (req1_bonus),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_port     (rsp_port),
    .rsp_result   (rsp_result),
    .rsp_zcv      (rsp_zcv),
    .rsp_err      (rsp_err),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_bonus    (alu_bonus),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow)
  );

  // Stand-in ALU; carry/overflow are forced high on non-arithmetic ops so the
  // DUT's masking is visible.
  logic [32:0] ext;
  always_comb begin
    ext          = '0;
    alu_result   = '0;
    alu_cout     = 1'b1;
    alu_overflow = 1'b1;
    case (alu_ctrl)
      4'd0:  alu_result = alu_src1 & alu_src2;
      4'd1:  alu_result = alu_src1 | alu_src2;
      4'd2: begin
        ext          = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = ext[31:0];
        alu_cout     = ext[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (ext[31] != alu_src1[31]);
      end
      4'd6: begin
        ext          = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_result   = ext[31:0];
        alu_cout     = ext[32];
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (ext[31] != alu_src1[31]);
      end
      4'd7: begin
        case (alu_bonus)
          3'd0: alu_result = {31'd0, $signed(alu_src1) <  $signed(alu_src2)};
          3'd1: alu_result = {31'd0, $signed(alu_src1) >  $signed(alu_src2)};
          3'd2: alu_result = {31'd0, $signed(alu_src1) <= $signed(alu_src2)};
          3'd3: alu_result = {31'd0, $signed(alu_src1) >= $signed(alu_src2)};
          3'd4: alu_result = {31'd0, alu_src1 != alu_src2};
          3'd6: alu_result = {31'd0, alu_src1 == alu_src2};
          default: alu_result = '0;
        endcase
      end
      4'd12: alu_result = ~(alu_src1 | alu_src2);
      4'd13: alu_result = ~(alu_src1 & alu_src2);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic [3:0] op,
                         input logic [2:0] bonus, input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_bonus = bonus; req0_src1 = a; req0_src2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_bonus = bonus; req1_src1 = a; req1_src2 = b;
    end
  endtask

  // Alternation table: {op, bonus, src1, src2, result, zcv}
  logic [3:0]  v_op  [8] = '{4'd1, 4'd12, 4'd7, 4'd7, 4'd13, 4'd2, 4'd6, 4'd7};
  logic [2:0]  v_bon [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd6};
  logic [31:0] v_a   [8] = '{32'hF0F0_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3};
  logic [31:0] v_b   [8] = '{32'h0000_0F0F, 32'h0, 32'h1, 32'h1,
                             32'hFFFF_FFFF, 32'h1, 32'h1, 32'h3};
  logic [31:0] v_res [8] = '{32'hF0F0_0F0F, 32'hFFFF_FFFF, 32'h1, 32'h0,
                             32'h0, 32'h0, 32'h7FFF_FFFF, 32'h1};
  logic [2:0]  v_zcv [8] = '{3'b000, 3'b000, 3'b000, 3'b100,
                             3'b100, 3'b110, 3'b011, 3'b000};

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 4'd0, 3'd0, 32'h0, 32'h0);
    set_req(1, 1'b0, 4'd0, 3'd0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_port", rsp_port, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zcv", rsp_zcv, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_src1", alu_src1, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    rst_n = 1'b1;

    // Port 0 ADD with signed overflow
    set_req(0, 1'b1, 4'd2, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    #1;
    chk("add_ready0", req0_ready, 1);
    chk("add_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("add_exec_no_valid", rsp_valid, 0);
    chk("add_exec_alu_src1", alu_src1, 32'h7FFF_FFFF);
    chk("add_exec_alu_ctrl", alu_ctrl, 4'd2);
    tick();
    chk("add_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 32'h8000_0000);
    chk("add_zcv", rsp_zcv, 3'b001);
    chk("add_port", rsp_port, 0);
    chk("add_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_back_idle", rsp_valid, 0);

    // Port 1 SUB equal operands, then AND with carry/overflow masked
    set_req(1, 1'b1, 4'd6, 3'd0, 32'h5, 32'h5);
    #1;
    chk("sub_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("sub_result", rsp_result, 32'h0);
    chk("sub_zcv", rsp_zcv, 3'b110);
    chk("sub_port", rsp_port, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 4'd0, 3'd0, 32'h5, 32'h5);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("and_valid", rsp_valid, 1);
    chk("and_result", rsp_result, 32'h5);
    chk("and_zcv", rsp_zcv, 3'b000);
    rsp_ready = 1'b1;
    tick();

    // Both ports continuously valid: grants alternate 0,1,0,1,...
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, v_op[k], v_bon[k], v_a[k], v_b[k]);
      set_req(1, 1'b1, v_op[k], v_bon[k], v_a[k], v_b[k]);
      #1;
      chk($sformatf("alt%0d_ready0", k), req0_ready, (k % 2) == 0);
      chk($sformatf("alt%0d_ready1", k), req1_ready, (k % 2) == 1);
      tick();
      tick();
      chk($sformatf("alt%0d_valid", k), rsp_valid, 1);
      chk($sformatf("alt%0d_port", k), rsp_port, k % 2);
      chk($sformatf("alt%0d_result", k), rsp_result, v_res[k]);
      chk($sformatf("alt%0d_zcv", k), rsp_zcv, v_zcv[k]);
      chk($sformatf("alt%0d_err", k), rsp_err, 0);
      tick();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("alt_end_idle", rsp_valid, 0);

    // Illegal op 7 / bonus 5 on port 0: response next cycle, ALU untouched
    set_req(0, 1'b1, 4'd7, 3'd5, 32'h1234, 32'h5678);
    #1;
    chk("ill_ready0", req0_ready, 1);
    tick();
    chk("ill_valid", rsp_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_result", rsp_result, 0);
    chk("ill_zcv", rsp_zcv, 0);
    chk("ill_port", rsp_port, 0);
    chk("ill_alu_src1", alu_src1, 32'h3);
    chk("ill_alu_ctrl", alu_ctrl, 4'd7);
    chk("ill_alu_bonus", alu_bonus, 3'd6);

    // Response stall: payload stable, no new requests accepted
    set_req(0, 1'b1, 4'd2, 3'd0, 32'h1, 32'h2);
    set_req(1, 1'b1, 4'd2, 3'd0, 32'h10, 32'h20);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d_ready0", i), req0_ready, 0);
      chk($sformatf("stall%0d_ready1", i), req1_ready, 0);
      chk($sformatf("stall%0d_valid", i), rsp_valid, 1);
      chk($sformatf("stall%0d_err", i), rsp_err, 1);
      chk($sformatf("stall%0d_port", i), rsp_port, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("stall_release_idle", rsp_valid, 0);
    chk("stall_next_ready1", req1_ready, 1);
    chk("stall_next_ready0", req0_ready, 0);

    // Reset while port 1's op is in EXEC
    tick();
    chk("mid_exec_alu_src1", alu_src1, 32'h10);
    rst_n = 1'b0;
    tick();
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_rsp_result", rsp_result, 0);
    chk("mrst_rsp_port", rsp_port, 0);
    chk("mrst_alu_src1", alu_src1, 0);
    chk("mrst_alu_ctrl", alu_ctrl, 0);
    chk("mrst_ready0", req0_ready, 0);
    chk("mrst_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_rsp0", rsp_valid, 0);
    tick();
    chk("post_rst_no_rsp1", rsp_valid, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_rst_ptr_ready0", req0_ready, 1);
    chk("post_rst_ptr_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    #1;
    chk("post_rst_solo_ready1", req1_ready, 1);
    chk("post_rst_solo_ready0", req0_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
